// File: rtl/fft_sequencer.sv
// fft_sequencer: loads samples bit-reversed, then sequences 64-point radix-2 DIT butterfly reads, twiddles and writebacks
module fft_sequencer #(
  parameter int N_LOG2 = 6
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              sample_valid,
  input  logic [15:0]       sample_data,
  output logic              sample_ready,
  input  logic [31:0]       a_out,
  input  logic [31:0]       b_out,
  output logic [N_LOG2-1:0] rd_adr_a,
  output logic [N_LOG2-1:0] rd_adr_b,
  output logic [N_LOG2-2:0] twiddle_adr,
  output logic [N_LOG2-1:0] wr_adr_a,
  output logic [N_LOG2-1:0] wr_adr_b,
  output logic [31:0]       wd_a,
  output logic [31:0]       wd_b,
  output logic              we_a,
  output logic              we_b,
  output logic              busy,
  output logic              done
);
  localparam int SW = $clog2(N_LOG2);
  typedef enum logic [2:0] {IDLE, LOAD, COMPUTE, GAP, DONE} state_t;
  state_t state, next;
  logic [N_LOG2-1:0] load_cnt, rev_cnt, adr_a, adr_b, wb_a, wb_b;
  logic [N_LOG2-2:0] idx, lo_mask, tw;
  logic [SW-1:0] stage;
  logic wb_v, load_we, last_stage;
  for (genvar j = 0; j < N_LOG2; j++) begin : g_rev
    assign rev_cnt[j] = load_cnt[N_LOG2-1-j];
  end
  // butterfly i of stage s: group base from the high bits of i, offset from the low s bits
  assign lo_mask = (N_LOG2-1)'((1 << stage) - 1);
  assign adr_a = ((N_LOG2'(idx) >> stage) << (stage + 1'b1)) | N_LOG2'(idx & lo_mask);
  assign adr_b = adr_a | (N_LOG2'(1) << stage);
  assign tw = (idx & lo_mask) << (SW'(N_LOG2 - 1) - stage);
  assign last_stage = stage == SW'(N_LOG2 - 1);
  assign load_we = state == LOAD && sample_valid;
  assign sample_ready = state == LOAD;
  assign busy = state == LOAD || state == COMPUTE || state == GAP;
  assign done = state == DONE;
  assign rd_adr_a = state == COMPUTE ? adr_a : '0;
  assign rd_adr_b = state == COMPUTE ? adr_b : '0;
  assign twiddle_adr = state == COMPUTE ? tw : '0;
  // writeback trails the read by one cycle, matching the RAM read latency
  assign we_a = load_we | wb_v;
  assign we_b = wb_v;
  assign wr_adr_a = load_we ? rev_cnt : wb_v ? wb_a : '0;
  assign wr_adr_b = wb_v ? wb_b : '0;
  assign wd_a = load_we ? {sample_data, 16'h0000} : wb_v ? a_out : '0;
  assign wd_b = wb_v ? b_out : '0;
  always_comb begin
    next = state;
    case (state)
      IDLE:    next = start ? LOAD : IDLE;
      LOAD:    next = (load_we && &load_cnt) ? COMPUTE : LOAD;
      COMPUTE: next = &idx ? GAP : COMPUTE;
      GAP:     next = last_stage ? DONE : COMPUTE;
      DONE:    next = IDLE;
      default: next = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      load_cnt <= '0;
      idx <= '0;
      stage <= '0;
      wb_v <= 1'b0;
      wb_a <= '0;
      wb_b <= '0;
    end else begin
      state <= next;
      load_cnt <= load_we ? load_cnt + 1'b1 : state == IDLE ? '0 : load_cnt;
      idx <= state == COMPUTE ? idx + 1'b1 : '0;
      stage <= state == GAP ? (last_stage ? '0 : stage + 1'b1) : state == IDLE ? '0 : stage;
      wb_v <= state == COMPUTE;
      wb_a <= rd_adr_a;
      wb_b <= rd_adr_b;
    end
  end
endmodule

// File: tb/tb_fft_sequencer.sv
// tb_fft_sequencer: scoreboard bench; expected RAM writes come from a stage/group/offset model of the FFT
module tb_fft_sequencer;
  logic clk = 0, reset, start, sample_valid, sample_ready;
  logic [15:0] sample_data;
  logic [31:0] a_out, b_out, wd_a, wd_b;
  logic [5:0] rd_adr_a, rd_adr_b, wr_adr_a, wr_adr_b;
  logic [4:0] twiddle_adr;
  logic we_a, we_b, busy, done;
  fft_sequencer #(.N_LOG2(6)) dut (
    .clk(clk), .reset(reset), .start(start), .sample_valid(sample_valid),
    .sample_data(sample_data), .sample_ready(sample_ready), .a_out(a_out), .b_out(b_out),
    .rd_adr_a(rd_adr_a), .rd_adr_b(rd_adr_b), .twiddle_adr(twiddle_adr),
    .wr_adr_a(wr_adr_a), .wr_adr_b(wr_adr_b), .wd_a(wd_a), .wd_b(wd_b),
    .we_a(we_a), .we_b(we_b), .busy(busy), .done(done)
  );
  always #5 clk = ~clk;
  typedef struct {int adr; logic [31:0] d;} ld_t;
  typedef struct {int a; int b; int tw;} bf_t;
  ld_t ld_q[$];
  bf_t bf_q[$];
  int errors = 0, checks = 0, cyc = 0, last_cyc = 0;
  int ndone = 0, nwb = 0, nab = 0;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask
  function automatic int bitrev(input int v);
    int r = 0;
    for (int b = 0; b < 6; b++) r = r * 2 + ((v >> b) & 1);
    return r;
  endfunction
  // stage s: groups of 2^(s+1) points, pairs (base+j, base+j+2^s), twiddle j*N/2^(s+1)
  task automatic push_bf();
    for (int s = 0; s < 6; s++)
      for (int g = 0; g < 64; g += (2 << s))
        for (int j = 0; j < (1 << s); j++)
          bf_q.push_back('{g + j, g + j + (1 << s), j * (32 >> s)});
  endtask
  initial forever begin
    @(posedge clk);
    cyc++;
    #1 a_out = $urandom;
    b_out = $urandom;
  end
  // monitor
  initial begin
    int pa = 0, pb = 0, ptw = 0, run = 0;
    logic pbusy = 0;
    ld_t l;
    bf_t e;
    forever begin
      @(negedge clk);
      if (reset) begin
        run = 0;
      end else begin
        if (we_a && sample_ready) begin
          chk("load_we_b", we_b, 0);
          if (ld_q.size() == 0) chk("load_unexpected", 1, 0);
          else begin
            l = ld_q.pop_front();
            chk("load_adr", wr_adr_a, l.adr);
            chk("load_wd", wd_a, l.d);
          end
        end else if (we_a != we_b) chk("we_pair", {31'b0, we_a}, {31'b0, we_b});
        if (we_b) begin
          nwb++;
          if (we_a) nab++;
          run++;
          if (bf_q.size() == 0) chk("bf_unexpected", 1, 0);
          else begin
            e = bf_q.pop_front();
            chk("rd_a", pa, e.a);
            chk("rd_b", pb, e.b);
            chk("tw", ptw, e.tw);
            chk("wr_a", wr_adr_a, e.a);
            chk("wr_b", wr_adr_b, e.b);
            chk("wd_a", wd_a, a_out);
            chk("wd_b", wd_b, b_out);
          end
        end else if (run > 0) begin
          chk("stage_run_len", run, 32);
          run = 0;
        end
        if (done) begin
          ndone++;
          chk("done_busy", busy, 0);
          chk("busy_before_done", pbusy, 1);
          chk("done_latency", cyc - last_cyc, 199);
        end
      end
      pa = rd_adr_a;
      pb = rd_adr_b;
      ptw = twiddle_adr;
      pbusy = busy;
    end
  end
  task automatic check_idle(input string nm);
    chk({nm, "_busy"}, busy, 0);
    chk({nm, "_done"}, done, 0);
    chk({nm, "_ready"}, sample_ready, 0);
    chk({nm, "_we"}, {we_a, we_b}, 0);
    chk({nm, "_rd"}, {rd_adr_a, rd_adr_b, twiddle_adr}, 0);
    chk({nm, "_wr"}, {wr_adr_a, wr_adr_b}, 0);
    chk({nm, "_wd"}, wd_a | wd_b, 0);
  endtask
  task automatic load_samples(input int n, input bit idx_data, input int pct);
    int k = 0, guard = 0;
    logic [15:0] d;
    chk("ready_in_load", sample_ready, 1);
    while (k < n && guard < 2000) begin
      guard++;
      if ($urandom_range(99) < pct) begin
        d = idx_data ? 16'(k) : 16'($urandom);
        sample_valid = 1;
        sample_data = d;
        ld_q.push_back('{bitrev(k), {d, 16'h0000}});
        last_cyc = cyc;
        k++;
        if (k == 64) push_bf();
      end else sample_valid = 0;
      @(posedge clk);
      #1;
    end
    sample_valid = 0;
    chk("load_count", k, n);
  endtask
  task automatic wait_done(input int limit);
    int t = 0, d0 = ndone;
    while (ndone == d0 && t < limit) begin
      @(posedge clk);
      t++;
    end
    chk("done_seen", ndone - d0, 1);
  endtask
  initial begin
    int w0, d0, a0;
    reset = 1; start = 0; sample_valid = 0; sample_data = 0; a_out = 0; b_out = 0;
    repeat (3) @(posedge clk);
    #1 check_idle("reset");
    reset = 0;
    @(posedge clk); #1;
    // partial load interrupted by reset
    start = 1;
    @(posedge clk); #1;
    start = 0;
    load_samples(10, 0, 70);
    reset = 1;
    #1 check_idle("mid_load_reset");
    ld_q.delete();
    bf_q.delete();
    @(posedge clk); @(posedge clk); #1;
    reset = 0;
    @(posedge clk); #1;
    chk("post_reset_ready", sample_ready, 0);
    chk("post_reset_busy", busy, 0);
    // full run, index samples, start held through load and part of compute
    w0 = nwb; a0 = nab; d0 = ndone;
    start = 1;
    @(posedge clk); #1;
    load_samples(64, 1, 100);
    repeat (100) @(posedge clk);
    #1 start = 0;
    wait_done(300);
    repeat (20) @(posedge clk);
    #1;
    chk("run1_we_b", nwb - w0, 192);
    chk("run1_we_a", nab - a0, 192);
    chk("run1_bf_left", bf_q.size(), 0);
    chk("run1_ld_left", ld_q.size(), 0);
    chk("run1_one_done", ndone - d0, 1);
    chk("run1_idle", busy, 0);
    // random stalls and data, start held, reset during stage 3
    start = 1;
    @(posedge clk); #1;
    load_samples(64, 0, 60);
    repeat (3 * 33 + 10) @(posedge clk);
    #1;
    chk("run2_busy", busy, 1);
    reset = 1;
    start = 0;
    bf_q.delete();
    w0 = nwb; d0 = ndone;
    #1 check_idle("stage3_reset");
    @(posedge clk); @(posedge clk); #1;
    reset = 0;
    repeat (60) @(posedge clk);
    #1;
    chk("run2_no_we", nwb - w0, 0);
    chk("run2_no_done", ndone - d0, 0);
    chk("run2_idle", busy, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
